// File: rtl/decoder_negedge_t.sv
// -----------------------------------------------------------------------------
// decoder_negedge_t
//
// Receive side of the negedge time-coded link. After a frame_start marker the
// block counts samples of incoming_line until the first low sample, then turns
// that delay k back into the thermometer value the encoder was loaded with
// (8'hFF >> k, or 8'h00 once k reaches 8). One registered result per frame,
// flagged by a single-cycle decoded_valid pulse. If the line never goes low
// inside the window, the result is reported with timeout set.
//
// Parameters
//   MAX_VALUE      measurement window length in samples (1..255)
//   TIME_W         width of the reported delay, derived from MAX_VALUE
//
// Ports
//   clock          in   sole clock, everything on posedge
//   reset          in   synchronous, active-high
//   frame_start    in   single-cycle frame marker (aligned with encoder load)
//   incoming_line  in   time-coded line, falls low to mark the value
//   decoded_value  out  recovered thermometer value, held until next result
//   decoded_time   out  recovered delay k in cycles, held until next result
//   decoded_valid  out  one-cycle pulse when the result registers update
//   timeout        out  set with decoded_valid when no low was seen
//
// Build option
//   DECODER_NEGEDGE_DEGLITCH_EN  when defined, a capture needs two consecutive
//   low samples (k and k+1, reported as k) and the window grows by one sample.
// -----------------------------------------------------------------------------
module decoder_negedge_t #(
  parameter  int MAX_VALUE = 8,
  localparam int TIME_W    = $clog2(MAX_VALUE + 1)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              frame_start,
  input  logic              incoming_line,
  output logic [7:0]        decoded_value,
  output logic [TIME_W-1:0] decoded_time,
  output logic              decoded_valid,
  output logic              timeout
);

  typedef enum logic {
    IDLE,
    MEASURE
  } state_t;

  localparam logic [TIME_W-1:0] MAX_T = TIME_W'(MAX_VALUE);

  state_t            state_q, state_d;
  logic [TIME_W-1:0] k_q, k_d;
  logic [7:0]        value_q, value_d;
  logic [TIME_W-1:0] time_q, time_d;
  logic              valid_q, valid_d;
  logic              timeout_q, timeout_d;
`ifdef DECODER_NEGEDGE_DEGLITCH_EN
  // Previous sample (k-1) of this frame was low.
  logic              low_prev_q, low_prev_d;
`endif

  // Delay -> thermometer value; delays of 8 or more leave no bits set.
  function automatic logic [7:0] thermo(input logic [TIME_W-1:0] k);
    if (int'(k) >= 8) begin
      thermo = 8'h00;
    end else begin
      thermo = 8'hFF >> k;
    end
  endfunction

  // Sample counter never wraps.
  function automatic logic [TIME_W-1:0] sat_inc(input logic [TIME_W-1:0] k);
    if (k == {TIME_W{1'b1}}) begin
      sat_inc = k;
    end else begin
      sat_inc = k + TIME_W'(1);
    end
  endfunction

  always_comb begin
    state_d    = state_q;
    k_d        = k_q;
    value_d    = value_q;
    time_d     = time_q;
    timeout_d  = timeout_q;
    valid_d    = 1'b0;
`ifdef DECODER_NEGEDGE_DEGLITCH_EN
    low_prev_d = low_prev_q;
`endif

    case (state_q)
      IDLE: begin
        if (frame_start) begin
          state_d    = MEASURE;
          k_d        = '0;
`ifdef DECODER_NEGEDGE_DEGLITCH_EN
          low_prev_d = 1'b0;
`endif
        end
      end

      MEASURE: begin
        // A new marker abandons the frame in flight; it beats any result
        // that would otherwise register on this edge.
        if (frame_start) begin
          k_d        = '0;
`ifdef DECODER_NEGEDGE_DEGLITCH_EN
          low_prev_d = 1'b0;
`endif
`ifdef DECODER_NEGEDGE_DEGLITCH_EN
        end else if (!incoming_line && low_prev_q) begin
          // Low confirmed on samples k-1 and k; the edge was at k-1.
          time_d    = k_q - TIME_W'(1);
          value_d   = thermo(k_q - TIME_W'(1));
          timeout_d = 1'b0;
          valid_d   = 1'b1;
          state_d   = IDLE;
        end else if (k_q == MAX_T) begin
          // Extra sample at index MAX_VALUE lets a low at MAX_VALUE-1 confirm.
          time_d    = MAX_T;
          value_d   = thermo(MAX_T);
          timeout_d = 1'b1;
          valid_d   = 1'b1;
          state_d   = IDLE;
        end else begin
          k_d        = sat_inc(k_q);
          low_prev_d = !incoming_line;
        end
`else
        end else if (!incoming_line) begin
          time_d    = k_q;
          value_d   = thermo(k_q);
          timeout_d = 1'b0;
          valid_d   = 1'b1;
          state_d   = IDLE;
        end else if (k_q == MAX_T - TIME_W'(1)) begin
          time_d    = MAX_T;
          value_d   = thermo(MAX_T);
          timeout_d = 1'b1;
          valid_d   = 1'b1;
          state_d   = IDLE;
        end else begin
          k_d = sat_inc(k_q);
        end
`endif
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      k_q        <= '0;
      value_q    <= 8'h00;
      time_q     <= '0;
      valid_q    <= 1'b0;
      timeout_q  <= 1'b0;
`ifdef DECODER_NEGEDGE_DEGLITCH_EN
      low_prev_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      k_q        <= k_d;
      value_q    <= value_d;
      time_q     <= time_d;
      valid_q    <= valid_d;
      timeout_q  <= timeout_d;
`ifdef DECODER_NEGEDGE_DEGLITCH_EN
      low_prev_q <= low_prev_d;
`endif
    end
  end

  assign decoded_value = value_q;
  assign decoded_time  = time_q;
  assign decoded_valid = valid_q;
  assign timeout       = timeout_q;

endmodule

// File: tb/tb_decoder_negedge_t.sv
// -----------------------------------------------------------------------------
// tb_decoder_negedge_t
//
// Builds a complete stimulus timeline (frame_start, incoming_line, reset per
// cycle) from directed frames, encoder-style loopback frames and random
// traffic. A frame-level reference model then scans that timeline: for every
// accepted frame_start it finds the deciding sample, drops frames cut short by
// another marker or reset, and schedules the expected result. Outputs are
// compared every cycle, 1 time unit after the rising edge.
// -----------------------------------------------------------------------------
module tb_decoder_negedge_t;

  localparam int MAXV   = 8;
  localparam int TW     = $clog2(MAXV + 1);
  localparam int NMAX   = 2048;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          frame_start = 1'b0;
  logic          incoming_line = 1'b1;
  logic [7:0]    decoded_value;
  logic [TW-1:0] decoded_time;
  logic          decoded_valid;
  logic          timeout;

  decoder_negedge_t #(.MAX_VALUE(MAXV)) dut (
    .clock         (clock),
    .reset         (reset),
    .frame_start   (frame_start),
    .incoming_line (incoming_line),
    .decoded_value (decoded_value),
    .decoded_time  (decoded_time),
    .decoded_valid (decoded_valid),
    .timeout       (timeout)
  );

  always #5 clock = ~clock;

  // Stimulus timeline, one entry per clock cycle.
  bit fs_a   [0:NMAX-1];
  bit line_a [0:NMAX-1];
  bit rst_a  [0:NMAX-1];
  int n = 0;

  // Expected outputs during each cycle.
  bit         ev_a   [0:NMAX];
  int         evt_a  [0:NMAX];
  bit         evto_a [0:NMAX];
  bit         xv_a   [0:NMAX];
  logic [7:0] xval_a [0:NMAX];
  int         xtim_a [0:NMAX];
  bit         xto_a  [0:NMAX];

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s cycle=%0d got=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic put(input bit f, input bit l, input bit r);
    if (n < NMAX - MAXV - 4) begin
      fs_a[n]   = f;
      line_a[n] = l;
      rst_a[n]  = r;
      n++;
    end
  endtask

  task automatic idle(input int cnt);
    for (int i = 0; i < cnt; i++) put(1'b0, 1'b1, 1'b0);
  endtask

  function automatic logic [7:0] value_of(input int k);
    return (k >= 8) ? 8'h00 : (8'hFF >> k);
  endfunction

  // Frame-level model: where each frame is decided, whether it survives,
  // and what it reports.
  task automatic build_expected();
    for (int t = 0; t <= NMAX; t++) begin
      ev_a[t] = 1'b0; evt_a[t] = 0; evto_a[t] = 1'b0;
    end
    for (int c = 0; c < n; c++) begin
      if (fs_a[c] && !rst_a[c]) begin
        int dsample;
        int tme;
        bit to;
        bit abort;
        int d;
        dsample = -1; tme = 0; to = 1'b0;
`ifdef DECODER_NEGEDGE_DEGLITCH_EN
        for (int j = 0; j < MAXV; j++) begin
          if (!line_a[c+1+j] && !line_a[c+2+j]) begin
            dsample = j + 1; tme = j; break;
          end
        end
        if (dsample < 0) begin dsample = MAXV; tme = MAXV; to = 1'b1; end
`else
        for (int j = 0; j < MAXV; j++) begin
          if (!line_a[c+1+j]) begin
            dsample = j; tme = j; break;
          end
        end
        if (dsample < 0) begin dsample = MAXV - 1; tme = MAXV; to = 1'b1; end
`endif
        d = c + 1 + dsample;
        abort = 1'b0;
        for (int t = c + 1; t <= d; t++) begin
          if (fs_a[t] || rst_a[t]) abort = 1'b1;
        end
        if (!abort && d + 1 <= NMAX) begin
          ev_a[d+1] = 1'b1; evt_a[d+1] = tme; evto_a[d+1] = to;
        end
      end
    end
    // Held outputs: result cycles load, reset clears, otherwise hold.
    xv_a[0] = 1'b0; xval_a[0] = 8'h00; xtim_a[0] = 0; xto_a[0] = 1'b0;
    for (int t = 1; t <= n; t++) begin
      xv_a[t] = 1'b0; xval_a[t] = xval_a[t-1]; xtim_a[t] = xtim_a[t-1]; xto_a[t] = xto_a[t-1];
      if (rst_a[t-1]) begin
        xval_a[t] = 8'h00; xtim_a[t] = 0; xto_a[t] = 1'b0;
      end else if (ev_a[t]) begin
        xv_a[t] = 1'b1; xval_a[t] = value_of(evt_a[t]); xtim_a[t] = evt_a[t]; xto_a[t] = evto_a[t];
      end
    end
  endtask

  initial begin
    for (int i = 0; i < NMAX; i++) begin
      fs_a[i] = 1'b0; line_a[i] = 1'b1; rst_a[i] = 1'b0;
    end

    // Reset, then idle.
    for (int i = 0; i < 3; i++) put(1'b0, 1'b1, 1'b1);
    idle(2);
    // Low at k=0.
    put(1'b1, 1'b1, 1'b0); put(1'b0, 1'b0, 1'b0); put(1'b0, 1'b0, 1'b0); idle(3);
    // High for 3 samples, then low.
    put(1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) put(1'b0, 1'b1, 1'b0);
    put(1'b0, 1'b0, 1'b0); put(1'b0, 1'b0, 1'b0); idle(3);
    // Line held high: timeout, then outputs hold.
    put(1'b1, 1'b1, 1'b0); idle(14);
    // Restart at k=2 with line high, then low one sample later.
    put(1'b1, 1'b1, 1'b0); put(1'b0, 1'b1, 1'b0); put(1'b0, 1'b1, 1'b0);
    put(1'b1, 1'b1, 1'b0); put(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) put(1'b0, 1'b0, 1'b0);
    idle(3);
    // Loopback: 8'hFF, 8'h7F, 8'h3F, 8'h0F back-to-back (k = 0, 1, 2, 4).
    begin
      int ks[4];
      ks = '{0, 1, 2, 4};
      foreach (ks[f]) begin
        put(1'b1, 1'b1, 1'b0);
        for (int i = 0; i < ks[f]; i++) put(1'b0, 1'b1, 1'b0);
`ifdef DECODER_NEGEDGE_DEGLITCH_EN
        put(1'b0, 1'b0, 1'b0); put(1'b0, 1'b0, 1'b0);
`else
        put(1'b0, 1'b0, 1'b0);
`endif
      end
    end
    idle(3);
    // Reset mid-frame.
    put(1'b1, 1'b1, 1'b0); put(1'b0, 1'b1, 1'b0); put(1'b0, 1'b1, 1'b1);
    put(1'b0, 1'b0, 1'b0); put(1'b0, 1'b0, 1'b0); idle(3);
    // Glitch at k=1, sustained low from k=4.
    put(1'b1, 1'b1, 1'b0); put(1'b0, 1'b1, 1'b0); put(1'b0, 1'b0, 1'b0);
    put(1'b0, 1'b1, 1'b0); put(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) put(1'b0, 1'b0, 1'b0);
    idle(3);
    // Random encoder-style frames, occasionally with a glitch or early restart.
    for (int f = 0; f < 40; f++) begin
      int k;
      int lows;
      k = $urandom_range(0, MAXV + 1);
      lows = $urandom_range(1, 4);
      put(1'b1, $urandom_range(0, 1) == 1, 1'b0);
      for (int i = 0; i < k; i++) put(1'b0, ($urandom_range(0, 7) != 0), 1'b0);
      for (int i = 0; i < lows; i++) put(1'b0, 1'b0, 1'b0);
      if ($urandom_range(0, 1) == 1) idle($urandom_range(0, 3));
    end
    // Unstructured random traffic.
    for (int i = 0; i < 600; i++) begin
      put($urandom_range(0, 5) == 0, $urandom_range(0, 2) != 0, $urandom_range(0, 149) == 0);
    end
    idle(30);

    build_expected();

    // Apply and compare.
    for (int c = 0; c < n; c++) begin
      @(negedge clock);
      frame_start   = fs_a[c];
      incoming_line = line_a[c];
      reset         = rst_a[c];
      @(posedge clock);
      #1;
      cyc = c + 1;
      check("valid",   32'(decoded_valid), 32'(xv_a[c+1]));
      check("value",   32'(decoded_value), 32'(xval_a[c+1]));
      check("time",    32'(decoded_time),  32'(xtim_a[c+1]));
      check("timeout", 32'(timeout),       32'(xto_a[c+1]));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_fail);
    $finish;
  end

endmodule
